counter_sweep_ctrl: RTL and testbench

Sequencer for the 6-bit up/down counter datapath (adder + ±1 direction mux + register).
- Drives the datapath's direction select, step enable and synchronous clear.
- Watches the datapath's count to run a triangular sweep: clear to 0, ramp up to HI, dwell, ramp down to LO, dwell, repeat until stopped.
- Sits between the top-level control inputs and the counter datapath, which gains a step-enable input for this purpose.

---
 rtl/counter_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Triangular sweep sequencer for the up/down counter datapath.
// Clears the count, ramps it between two limits with a dwell at each end, and counts completed sweeps.
`timescale 1ns/1ps

module counter_sweep_ctrl #(
    parameter int WIDTH   = 6,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   lo_limit,
    input  logic [WIDTH-1:0]   hi_limit,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [WIDTH-1:0]   count_in,
    output logic               direction,
    output logic               step_en,
    output logic               clr,
    output logic               busy,
    output logic               cfg_err,
    output logic [SWEEP_W-1:0] sweeps
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_UP,
        S_HOLD_HI,
        S_DOWN,
        S_HOLD_LO
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic               cfg_err_q, cfg_err_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;

    logic at_hi;
    logic at_lo;
    logic dwell_done;

    assign at_hi      = (count_in == hi_q);
    assign at_lo      = (count_in == lo_q);
    assign dwell_done = (dcnt_q == '0);

    // Next-state and datapath controls; stop overrides everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        dwell_d   = dwell_q;
        dcnt_d    = dcnt_q;
        cfg_err_d = cfg_err_q;
        sweeps_d  = sweeps_q;
        direction = 1'b0;
        step_en   = 1'b0;
        clr       = 1'b0;
        busy      = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (!stop && start) begin
                    if (lo_limit < hi_limit) begin
                        lo_d      = lo_limit;
                        hi_d      = hi_limit;
                        dwell_d   = dwell;
                        cfg_err_d = 1'b0;
                        state_d   = S_CLR;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_CLR: begin
                clr     = 1'b1;
                state_d = S_UP;
            end
            S_UP: begin
                step_en = !at_hi;
                if (at_hi) begin
                    state_d = S_HOLD_HI;
                    dcnt_d  = dwell_q;
                end
            end
            S_HOLD_HI: begin
                direction = 1'b1;
                if (dwell_done) begin
                    state_d = S_DOWN;
                end else begin
                    dcnt_d = dcnt_q - DWELL_W'(1);
                end
            end
            S_DOWN: begin
                direction = 1'b1;
                step_en   = !at_lo;
                if (at_lo) begin
                    state_d  = S_HOLD_LO;
                    dcnt_d   = dwell_q;
                    sweeps_d = sweeps_q + SWEEP_W'(1);
                end
            end
            S_HOLD_LO: begin
                if (dwell_done) begin
                    state_d = S_UP;
                end else begin
                    dcnt_d = dcnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop && (state_q != S_IDLE)) begin
            step_en  = 1'b0;
            clr      = 1'b0;
            state_d  = S_IDLE;
            dcnt_d   = dcnt_q;
            sweeps_d = sweeps_q;
        end
    end

    // State, captured configuration and status registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
            dcnt_q    <= '0;
            cfg_err_q <= 1'b0;
            sweeps_q  <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dwell_q   <= dwell_d;
            dcnt_q    <= dcnt_d;
            cfg_err_q <= cfg_err_d;
            sweeps_q  <= sweeps_d;
        end
    end

    assign cfg_err = cfg_err_q;
    assign sweeps  = sweeps_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl with a behavioural counter datapath.
// Expected per-cycle outputs are queued ahead and compared as cycles elapse.
`timescale 1ns/1ps

module tb_counter_sweep_ctrl;

    localparam int W  = 6;
    localparam int DW = 4;
    localparam int SW = 8;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [W-1:0]  lo_limit = '0;
    logic [W-1:0]  hi_limit = '0;
    logic [DW-1:0] dwell = '0;
    logic [W-1:0]  cnt;
    logic          direction;
    logic          step_en;
    logic          clr;
    logic          busy;
    logic          cfg_err;
    logic [SW-1:0] sweeps;

    always #5 CLK = ~CLK;

    counter_sweep_ctrl #(
        .WIDTH(W),
        .DWELL_W(DW),
        .SWEEP_W(SW)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .start(start),
        .stop(stop),
        .lo_limit(lo_limit),
        .hi_limit(hi_limit),
        .dwell(dwell),
        .count_in(cnt),
        .direction(direction),
        .step_en(step_en),
        .clr(clr),
        .busy(busy),
        .cfg_err(cfg_err),
        .sweeps(sweeps)
    );

    // Counter datapath: clear, or step by +/-1, reset shared with the sequencer.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (step_en) begin
            cnt <= direction ? cnt - W'(1) : cnt + W'(1);
        end
    end

    typedef struct {
        logic [4:0]    ctl;
        logic [SW-1:0] swp;
        logic [W-1:0]  cnt;
    } rec_t;

    rec_t          sb[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [SW-1:0] e_swp = '0;
    logic          e_cfg = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (vector %0d, t=%0t)",
                     tag, got, exp, n_vec, $time);
        end
    endtask

    task automatic push(input logic b, input logic c, input logic s,
                        input logic d, input logic [W-1:0] v);
        rec_t r;
        r.ctl = {b, c, s, d, e_cfg};
        r.swp = e_swp;
        r.cnt = v;
        sb.push_back(r);
    endtask

    task automatic step();
        rec_t r;
        #2;
        r = sb.pop_front();
        chk("ctl{busy,clr,step,dir,err}",
            {27'd0, busy, clr, step_en, direction, cfg_err}, {27'd0, r.ctl});
        chk("sweeps", {24'd0, sweeps}, {24'd0, r.swp});
        chk("count", {26'd0, cnt}, {26'd0, r.cnt});
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        while (sb.size() > 0) step();
    endtask

    task automatic idle(input logic [W-1:0] v, input int n);
        repeat (n) push(1'b0, 1'b0, 1'b0, 1'b0, v);
    endtask

    task automatic up(input int from, input int to);
        for (int c = from; c <= to; c++)
            push(1'b1, 1'b0, c != to, 1'b0, W'(c));
    endtask

    task automatic down(input int from, input int to);
        for (int c = from; c >= to; c--)
            push(1'b1, 1'b0, c != to, 1'b1, W'(c));
        e_swp = e_swp + SW'(1);
    endtask

    task automatic hold(input logic [W-1:0] v, input logic d, input int n);
        repeat (n) push(1'b1, 1'b0, 1'b0, d, v);
    endtask

    task automatic go(input logic [W-1:0] lo, input logic [W-1:0] hi,
                      input logic [DW-1:0] dw, input logic keep,
                      input logic [W-1:0] cnow);
        lo_limit = lo;
        hi_limit = hi;
        dwell    = dw;
        start    = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, cnow);
        drain();
        if (!keep) start = 1'b0;
        if (lo < hi) begin
            e_cfg = 1'b0;
            push(1'b1, 1'b1, 1'b0, 1'b0, cnow);
        end else begin
            e_cfg = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        idle(6'd0, 2);
        drain();

        // lo=2 hi=5 dwell=1: full sweep and back up, stop in HOLD_HI
        go(6'd2, 6'd5, 4'd1, 1'b0, 6'd0);
        up(0, 5);
        hold(6'd5, 1'b1, 2);
        down(5, 2);
        hold(6'd2, 1'b0, 2);
        up(2, 5);
        drain();
        stop = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
        drain();
        stop = 1'b0;
        idle(6'd5, 2);
        drain();

        // rejected start (lo == hi), then a valid one clears cfg_err
        go(6'd5, 6'd5, 4'd0, 1'b0, 6'd5);
        idle(6'd5, 3);
        drain();
        go(6'd0, 6'd3, 4'd2, 1'b0, 6'd5);
        up(0, 3);
        hold(6'd3, 1'b1, 3);
        down(3, 0);
        hold(6'd0, 1'b0, 3);
        push(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        drain();
        stop = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 6'd1);
        drain();
        stop = 1'b0;
        idle(6'd1, 1);
        drain();

        // dwell=0, lo=0 hi=1: single-cycle holds
        go(6'd0, 6'd1, 4'd0, 1'b0, 6'd1);
        up(0, 1);
        hold(6'd1, 1'b1, 1);
        down(1, 0);
        hold(6'd0, 1'b0, 1);
        up(0, 1);
        hold(6'd1, 1'b1, 1);
        down(1, 0);
        hold(6'd0, 1'b0, 1);
        drain();
        stop = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        drain();
        stop = 1'b0;
        idle(6'd0, 1);
        drain();

        // stop at count 3 while ramping to 10; then start+stop in IDLE
        go(6'd0, 6'd10, 4'd3, 1'b0, 6'd0);
        for (int c = 0; c < 3; c++) push(1'b1, 1'b0, 1'b1, 1'b0, W'(c));
        drain();
        stop = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 6'd3);
        drain();
        start = 1'b1;
        idle(6'd3, 2);
        drain();
        start = 1'b0;
        stop  = 1'b0;
        idle(6'd3, 1);
        drain();

        // asynchronous reset between edges while ramping down
        go(6'd0, 6'd4, 4'd1, 1'b0, 6'd3);
        up(0, 4);
        hold(6'd4, 1'b1, 2);
        push(1'b1, 1'b0, 1'b1, 1'b1, 6'd4);
        push(1'b1, 1'b0, 1'b1, 1'b1, 6'd3);
        drain();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        e_swp = '0;
        e_cfg = 1'b0;
        idle(6'd0, 2);
        drain();
        go(6'd1, 6'd3, 4'd0, 1'b0, 6'd0);
        up(0, 3);
        hold(6'd3, 1'b1, 1);
        down(3, 1);
        hold(6'd1, 1'b0, 1);
        drain();
        stop = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0, 6'd1);
        drain();
        stop = 1'b0;
        idle(6'd1, 1);
        drain();

        // start held high across a running sweep: no re-clear
        go(6'd1, 6'd3, 4'd0, 1'b1, 6'd1);
        up(0, 3);
        hold(6'd3, 1'b1, 1);
        down(3, 1);
        hold(6'd1, 1'b0, 1);
        up(1, 3);
        drain();
        stop = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b1, 6'd3);
        drain();
        idle(6'd3, 2);
        drain();
        start = 1'b0;
        stop  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
